// File: rtl/vram_write_sched_pkg.sv
// Shared types for the framebuffer write scheduler: fill FSM states and
// round-robin side encoding.
package vram_write_sched_pkg;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_DONE = 2'd2
  } fill_state_e;

  typedef enum logic {
    RR_CPU  = 1'b0,
    RR_FILL = 1'b1
  } rr_side_e;

  function automatic rr_side_e rr_other(input rr_side_e side);
    return (side == RR_CPU) ? RR_FILL : RR_CPU;
  endfunction

endpackage

// File: rtl/vram_write_sched_sync_fifo.sv
// Small synchronous FIFO holding buffered CPU stores; power-of-two depth so
// the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/vram_write_sched.sv
// Framebuffer write scheduler: round-robin between buffered CPU stores and a
// constant-fill engine, issuing registered writes only while vram_ok is high.
module vram_write_sched
  import vram_write_sched_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clki,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_rdy,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [ADDR_W-1:0] fill_len,
  input  logic [DATA_W-1:0] fill_val,
  output logic              fill_busy,
  output logic              fill_done,
  input  logic              vram_ok,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_data
);

  logic [ADDR_W+DATA_W-1:0] fifo_rdata;
  logic                     fifo_full, fifo_empty;
  logic                     cpu_pend, fill_pend, cpu_grant, fill_grant;

  fill_state_e       state_q, state_d;
  rr_side_e          rr_q, rr_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d, fill_rem_q, fill_rem_d;
  logic [DATA_W-1:0] fill_val_q, fill_val_d;
  logic              vram_we_q, vram_we_d;
  logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
  logic [DATA_W-1:0] vram_data_q, vram_data_d;

  assign cpu_rdy   = ~fifo_full & ~rst;
  assign cpu_pend  = ~fifo_empty;
  assign fill_pend = (state_q == FS_RUN);
  assign fill_busy = (state_q == FS_RUN);
  assign fill_done = (state_q == FS_DONE);
  assign vram_we   = vram_we_q;
  assign vram_addr = vram_addr_q;
  assign vram_data = vram_data_q;

  sync_fifo #(
    .WIDTH(ADDR_W + DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clki),
    .rst  (rst),
    .push (cpu_req & cpu_rdy),
    .pop  (cpu_grant),
    .wdata({cpu_addr, cpu_data}),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // rr only moves on a contested grant; an uncontested side is served directly.
  always_comb begin
    cpu_grant  = 1'b0;
    fill_grant = 1'b0;
    rr_d       = rr_q;
    if (vram_ok) begin
      if (cpu_pend && fill_pend) begin
        if (rr_q == RR_CPU) cpu_grant = 1'b1;
        else                fill_grant = 1'b1;
        rr_d = rr_other(rr_q);
      end else if (cpu_pend) begin
        cpu_grant = 1'b1;
      end else if (fill_pend) begin
        fill_grant = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    fill_rem_d  = fill_rem_q;
    fill_val_d  = fill_val_q;
    case (state_q)
      FS_IDLE: begin
        if (fill_start) begin
          fill_addr_d = fill_base;
          fill_rem_d  = fill_len;
          fill_val_d  = fill_val;
          state_d     = (fill_len == '0) ? FS_DONE : FS_RUN;
        end
      end
      FS_RUN: begin
        if (fill_grant) begin
          fill_addr_d = fill_addr_q + ADDR_W'(1);
          fill_rem_d  = fill_rem_q - ADDR_W'(1);
          if (fill_rem_q == ADDR_W'(1)) state_d = FS_DONE;
        end
      end
      FS_DONE: state_d = FS_IDLE;
      default: state_d = FS_IDLE;
    endcase
  end

  // Address/data hold their last value between strobes.
  always_comb begin
    vram_we_d   = cpu_grant | fill_grant;
    vram_addr_d = vram_addr_q;
    vram_data_d = vram_data_q;
    if (cpu_grant) begin
      vram_addr_d = fifo_rdata[ADDR_W+DATA_W-1:DATA_W];
      vram_data_d = fifo_rdata[DATA_W-1:0];
    end else if (fill_grant) begin
      vram_addr_d = fill_addr_q;
      vram_data_d = fill_val_q;
    end
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      state_q     <= FS_IDLE;
      rr_q        <= RR_CPU;
      fill_addr_q <= '0;
      fill_rem_q  <= '0;
      fill_val_q  <= '0;
      vram_we_q   <= 1'b0;
      vram_addr_q <= '0;
      vram_data_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      fill_addr_q <= fill_addr_d;
      fill_rem_q  <= fill_rem_d;
      fill_val_q  <= fill_val_d;
      vram_we_q   <= vram_we_d;
      vram_addr_q <= vram_addr_d;
      vram_data_q <= vram_data_d;
    end
  end

endmodule
